// File: rtl/vote_tally_scan.sv
// Four-candidate vote counter with button lockout and a 3-cycle winner scan
// that shares one external 4-bit magnitude comparator.
module vote_tally_scan #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             poll_open,
  input  logic             close_poll,
  input  logic [3:0]       cand_sel,
  input  logic             result_ack,
  input  logic [1:0]       rd_sel,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic [CNT_W-1:0] cmp_a,
  output logic [CNT_W-1:0] cmp_b,
  output logic [CNT_W-1:0] rd_count,
  output logic             vote_ok,
  output logic             vote_bad,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       winner_id,
  output logic [CNT_W-1:0] winner_cnt,
  output logic             tie,
  output logic             sat
);

  // state   | meaning
  // IDLE    | no poll running, waiting for poll_open
  // VOTING  | accepting a single button press
  // LOCKOUT | vote taken or rejected, waiting for all buttons released
  // SCAN    | walking tallies 1..3 through the external comparator
  // DONE    | result presented until result_ack
  typedef enum logic [2:0] {
    S_IDLE, S_VOTING, S_LOCKOUT, S_SCAN, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tally [NUM_CAND];
  logic [CNT_W-1:0] best;
  logic [1:0]       best_id;
  logic [1:0]       scan_idx;
  logic             tie_r;
  logic             one_hot, multi;
  logic             clear, vote_take, vote_rej, scan_start;

  assign one_hot = (cand_sel != 4'd0) && ((cand_sel & (cand_sel - 4'd1)) == 4'd0);
  assign multi   = (cand_sel != 4'd0) && !one_hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // close_poll is checked before any button so a simultaneous press is dropped
  always_comb begin
    state_nxt  = state;
    clear      = 1'b0;
    vote_take  = 1'b0;
    vote_rej   = 1'b0;
    scan_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (poll_open) begin
          clear     = 1'b1;
          state_nxt = S_VOTING;
        end
      end
      S_VOTING: begin
        if (close_poll) begin
          scan_start = 1'b1;
          state_nxt  = S_SCAN;
        end else if (one_hot) begin
          vote_take = 1'b1;
          state_nxt = S_LOCKOUT;
        end else if (multi) begin
          vote_rej  = 1'b1;
          state_nxt = S_LOCKOUT;
        end
      end
      S_LOCKOUT: begin
        if (close_poll) begin
          scan_start = 1'b1;
          state_nxt  = S_SCAN;
        end else if (cand_sel == 4'd0) begin
          state_nxt = S_VOTING;
        end
      end
      S_SCAN: begin
        if (scan_idx == 2'd3) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (result_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CAND; c++) tally[c] <= '0;
      sat      <= 1'b0;
      best     <= '0;
      best_id  <= '0;
      tie_r    <= 1'b0;
      scan_idx <= '0;
      vote_ok  <= 1'b0;
      vote_bad <= 1'b0;
    end else begin
      vote_ok  <= vote_take;
      vote_bad <= vote_rej;
      if (clear) begin
        for (int c = 0; c < NUM_CAND; c++) tally[c] <= '0;
        sat <= 1'b0;
      end
      if (vote_take) begin
        for (int c = 0; c < NUM_CAND; c++) begin
          if (cand_sel[c]) begin
            if (tally[c] == CNT_MAX) sat <= 1'b1;
            else                     tally[c] <= tally[c] + 1'b1;
          end
        end
      end
      if (scan_start) begin
        best     <= tally[0];
        best_id  <= '0;
        tie_r    <= 1'b0;
        scan_idx <= 2'd1;
      end else if (state == S_SCAN) begin
        // strict greater keeps the lower index on equal tallies
        if (cmp_gt) begin
          best    <= tally[scan_idx];
          best_id <= scan_idx;
          tie_r   <= 1'b0;
        end else if (cmp_eq) begin
          tie_r <= 1'b1;
        end
        scan_idx <= scan_idx + 1'b1;
      end
    end
  end

  assign busy         = (state == S_SCAN);
  assign result_valid = (state == S_DONE);
  assign cmp_a        = busy ? tally[scan_idx] : '0;
  assign cmp_b        = busy ? best : '0;
  assign rd_count     = tally[rd_sel];
  assign winner_id    = result_valid ? best_id : '0;
  assign winner_cnt   = result_valid ? best : '0;
  assign tie          = result_valid ? tie_r : 1'b0;

endmodule

// File: tb/tb_vote_tally_scan.sv
// Randomized and directed bench for vote_tally_scan against a poll-level
// reference model; the external comparator is modelled with plain compares.
module tb_vote_tally_scan;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       poll_open, close_poll, result_ack;
  logic [3:0] cand_sel;
  logic [1:0] rd_sel;
  logic       cmp_gt, cmp_eq;
  logic [3:0] cmp_a, cmp_b, rd_count, winner_cnt;
  logic       vote_ok, vote_bad, busy, result_valid, tie, sat;
  logic [1:0] winner_id;

  int checks = 0;
  int failures = 0;
  int ok_seen = 0;

  always #5 clk = ~clk;

  assign cmp_gt = (cmp_a > cmp_b);
  assign cmp_eq = (cmp_a == cmp_b);

  vote_tally_scan #(.NUM_CAND(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .poll_open(poll_open), .close_poll(close_poll),
    .cand_sel(cand_sel), .result_ack(result_ack), .rd_sel(rd_sel),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .rd_count(rd_count), .vote_ok(vote_ok), .vote_bad(vote_bad), .busy(busy),
    .result_valid(result_valid), .winner_id(winner_id), .winner_cnt(winner_cnt),
    .tie(tie), .sat(sat)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // poll-level model: phase of the poll, tallies, and whether buttons were released
  localparam int P_IDLE = 0, P_OPEN = 1, P_SCAN = 2, P_DONE = 3;
  int m_phase, m_k;
  int m_t [4];
  bit m_armed, m_sat, m_ok, m_bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE; m_k <= 0; m_armed <= 0; m_sat <= 0; m_ok <= 0; m_bad <= 0;
      for (int i = 0; i < 4; i++) m_t[i] <= 0;
    end else begin
      m_ok  <= 0;
      m_bad <= 0;
      case (m_phase)
        P_IDLE: if (poll_open) begin
          for (int i = 0; i < 4; i++) m_t[i] <= 0;
          m_sat <= 0; m_armed <= 1; m_phase <= P_OPEN;
        end
        P_OPEN: begin
          if (close_poll) begin
            m_phase <= P_SCAN; m_k <= 0;
          end else if (!m_armed) begin
            if (cand_sel == 4'd0) m_armed <= 1;
          end else if ($countones(cand_sel) == 1) begin
            m_armed <= 0; m_ok <= 1;
            for (int i = 0; i < 4; i++)
              if (cand_sel[i]) begin
                if (m_t[i] == 15) m_sat <= 1;
                else m_t[i] <= m_t[i] + 1;
              end
          end else if ($countones(cand_sel) > 1) begin
            m_armed <= 0; m_bad <= 1;
          end
        end
        P_SCAN: if (m_k == 2) m_phase <= P_DONE; else m_k <= m_k + 1;
        default: if (result_ack) m_phase <= P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    int mx, id, n, pre;
    if (vote_ok) ok_seen++;
    if (!rst_n) begin
      chk("rst_outputs", {cmp_a, cmp_b, rd_count, winner_cnt, winner_id, vote_ok,
                          vote_bad, busy, result_valid, tie, sat}, 0);
    end else begin
      mx = -1; id = 0; n = 0;
      for (int i = 0; i < 4; i++) if (m_t[i] > mx) begin mx = m_t[i]; id = i; end
      for (int i = 0; i < 4; i++) if (m_t[i] == mx) n++;
      chk("vote_ok", vote_ok, m_ok);
      chk("vote_bad", vote_bad, m_bad);
      chk("busy", busy, m_phase == P_SCAN);
      chk("result_valid", result_valid, m_phase == P_DONE);
      chk("sat", sat, m_sat);
      chk("rd_count", rd_count, m_t[rd_sel]);
      if (m_phase == P_SCAN) begin
        pre = 0;
        for (int i = 0; i <= m_k; i++) if (m_t[i] > pre) pre = m_t[i];
        chk("cmp_a", cmp_a, m_t[m_k + 1]);
        chk("cmp_b", cmp_b, pre);
      end else begin
        chk("cmp_a_idle", cmp_a, 0);
        chk("cmp_b_idle", cmp_b, 0);
      end
      if (m_phase == P_DONE) begin
        chk("winner_id", winner_id, id);
        chk("winner_cnt", winner_cnt, mx);
        chk("tie", tie, n > 1);
      end
    end
  end

  // inputs are applied just after a rising edge and sampled on the next one
  task automatic cyc(input logic [3:0] sel, input logic po = 0, input logic cp = 0,
                     input logic ack = 0);
    cand_sel = sel; poll_open = po; close_poll = cp; result_ack = ack;
    rd_sel = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    poll_open = 0; close_poll = 0; result_ack = 0;
  endtask

  task automatic vote(input int c);
    cyc(4'(1 << c));
    cyc(4'd0);
  endtask

  task automatic peek(input int idx, input string nm, input int exp);
    rd_sel = 2'(idx); #1;
    chk(nm, rd_count, exp);
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int k = 0; k < 12 && !result_valid; k++) begin
      if (busy) nbusy++;
      cyc(4'd0);
    end
    if (!result_valid) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, nb;
    logic [3:0] s;
    rst_n = 0; poll_open = 0; close_poll = 0; result_ack = 0; cand_sel = 0; rd_sel = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    cyc(4'd0);
    chk("reset_idle_valid", result_valid, 0);

    // V1: held button counts once
    cyc(4'd0, 1);
    base = ok_seen;
    repeat (5) cyc(4'b0100);
    cyc(4'd0);
    peek(2, "v1_tally2", 1);
    chk("v1_ok_pulses", ok_seen - base, 1);
    cyc(4'd0, 0, 1); wait_done(nb); cyc(4'd0, 0, 0, 1);

    // V2: 3/5/2/5 -> lowest-index tie winner
    cyc(4'd0, 1);
    repeat (3) vote(0);
    repeat (5) vote(1);
    repeat (2) vote(2);
    repeat (5) vote(3);
    cyc(4'd0, 0, 1);
    wait_done(nb);
    chk("v2_busy_cycles", nb, 3);
    chk("v2_winner_id", winner_id, 1);
    chk("v2_winner_cnt", winner_cnt, 5);
    chk("v2_tie", tie, 1);
    cyc(4'd0, 0, 0, 1);

    // V3: multi-press rejected, then lockout until release
    cyc(4'd0, 1);
    cyc(4'b0011);
    chk("v3_bad_pulse", vote_bad, 1);
    cyc(4'b0011);
    cyc(4'b0001);
    cyc(4'b0001);
    peek(0, "v3_tally0_locked", 0);
    peek(1, "v3_tally1", 0);
    cyc(4'd0);
    cyc(4'b0001);
    cyc(4'd0);
    peek(0, "v3_tally0_after", 1);
    cyc(4'd0, 0, 1); wait_done(nb); cyc(4'd0, 0, 0, 1);

    // V4: saturation
    cyc(4'd0, 1);
    base = ok_seen;
    repeat (16) vote(0);
    peek(0, "v4_tally0", 15);
    chk("v4_sat", sat, 1);
    chk("v4_ok_pulses", ok_seen - base, 16);
    cyc(4'd0, 0, 1); wait_done(nb); cyc(4'd0, 0, 0, 1);

    // V5: close wins over a same-cycle press
    cyc(4'd0, 1);
    vote(3);
    cyc(4'b1000, 0, 1);
    chk("v5_busy", busy, 1);
    peek(3, "v5_tally3", 1);
    wait_done(nb);
    chk("v5_winner_id", winner_id, 3);
    chk("v5_tie", tie, 0);
    cyc(4'd0, 0, 0, 1);

    // V6: reset during scan, then ack keeps tallies readable
    cyc(4'd0, 1);
    vote(1); vote(2);
    cyc(4'd0, 0, 1);
    cyc(4'd0);
    rst_n = 0; #1;
    chk("v6_rst_busy", busy, 0);
    peek(1, "v6_rst_tally1", 0);
    cyc(4'd0);
    rst_n = 1;
    cyc(4'd0);
    chk("v6_post_rst_valid", result_valid, 0);
    cyc(4'd0, 1);
    vote(2); vote(2);
    cyc(4'd0, 0, 1);
    wait_done(nb);
    chk("v6_winner_cnt", winner_cnt, 2);
    cyc(4'd0, 0, 0, 1);
    chk("v6_ack_valid", result_valid, 0);
    peek(2, "v6_tally2_kept", 2);

    // random traffic across all phases
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9: s = 4'd0;
        10, 11, 12, 13, 14, 15, 16:   s = 4'(1 << $urandom_range(0, 3));
        default:                      s = 4'($urandom_range(0, 15));
      endcase
      cyc(s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0),
          ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0; cyc(4'd0); rst_n = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vote_tally_scan.md
VOTE_TALLY_SCAN -- requirements
Module: vote_tally_scan

Interface
REQ-001 The module SHALL have parameter NUM_CAND, default 4, meaning the number of candidates; it is fixed at 4 and other values are unsupported.
REQ-002 The module SHALL have parameter CNT_W, default 4, meaning the tally width, which matches the 4-bit comparator.
REQ-003 The ports SHALL be as follows; one clock; reset is asynchronous and active-low.
  clk          in   1      system clock, rising edge
  rst_n        in   1      asynchronous active-low reset
  poll_open    in   1      pulse: start a new poll, clear tallies
  close_poll   in   1      pulse: end voting, start winner scan
  cand_sel     in   4      candidate buttons, level, one-hot expected
  result_ack   in   1      pulse: result consumed, return to IDLE
  rd_sel       in   2      tally read index
  cmp_gt       in   1      A_greater_B from external comparator
  cmp_eq       in   1      A_equal_B from external comparator
  cmp_a        out  4      comparator operand A (candidate under test)
  cmp_b        out  4      comparator operand B (current best)
  rd_count     out  4      tally[rd_sel], combinational
  vote_ok      out  1      1-cycle pulse: vote counted
  vote_bad     out  1      1-cycle pulse: multi-button press rejected
  busy         out  1      high in SCAN
  result_valid out  1      high in DONE
  winner_id    out  2      index of the highest tally
  winner_cnt   out  4      tally of the winner
  tie          out  1      another candidate equals the winner tally
  sat          out  1      sticky: a vote hit a saturated tally

Function
REQ-004 The FSM SHALL have the states IDLE, VOTING, LOCKOUT, SCAN and DONE.
REQ-005 In IDLE, poll_open SHALL clear all tallies and sat, then move to VOTING; close_poll, cand_sel and result_ack SHALL be ignored in IDLE.
REQ-006 In VOTING, a cand_sel value with exactly one bit set SHALL increment that tally, pulse vote_ok in the next cycle and move to LOCKOUT.
REQ-007 In VOTING, a cand_sel value with two or more bits set SHALL leave all tallies unchanged, pulse vote_bad and move to LOCKOUT.
REQ-008 LOCKOUT SHALL return to VOTING only on the first cycle in which cand_sel==0, so a held button counts once.
REQ-009 A tally at 15 SHALL stay at 15 on a further vote; vote_ok still pulses and sat is set.
REQ-010 close_poll in VOTING or LOCKOUT SHALL move to SCAN and takes priority over a vote in the same cycle, which is discarded with no pulse.
REQ-011 On SCAN entry, best SHALL be set to tally[0], with best_id=0, tie=0 and scan index i=1.
REQ-012 Each SCAN cycle SHALL drive cmp_a=tally[i] and cmp_b=best, and sample cmp_gt/cmp_eq in the same cycle (the comparator is combinational).
REQ-013 On a SCAN cycle with cmp_gt=1, the block SHALL set best=tally[i], best_id=i and tie=0.
REQ-014 On a SCAN cycle with cmp_eq=1, the block SHALL set tie=1.
REQ-015 After each SCAN cycle the block SHALL increment i; after i=3 it SHALL move to DONE, so SCAN lasts exactly 3 cycles.
REQ-016 Outside SCAN, cmp_a and cmp_b SHALL be 0.
REQ-017 On a tie, the lowest index among the tied-highest candidates SHALL win.
REQ-018 In DONE, result_valid=1 and winner_id, winner_cnt and tie SHALL hold stable until result_ack, which moves to IDLE; tallies are retained for rd_count.
REQ-019 poll_open SHALL be ignored in every state except IDLE.

Reset
REQ-020 When rst_n=0, the block SHALL asynchronously set the state to IDLE, all tallies, sat, best, best_id, tie and i to 0, and all outputs to 0.
REQ-021 When reset is asserted mid-vote or mid-scan, the block SHALL discard all partial state; the first cycle after release is IDLE.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
  V1: poll_open; press cand 2 held 5 cycles; release -> tally[2]=1, one vote_ok pulse.
  V2: votes 3/5/2/5 for cand 0..3; close_poll -> busy for 3 cycles, then winner_id=1, winner_cnt=5, tie=1.
  V3: cand_sel=4'b0011 in VOTING -> vote_bad pulse, all tallies unchanged, no vote until cand_sel==0.
  V4: 16 votes for cand 0 -> tally[0]=15, sat=1, 16 vote_ok pulses.
  V5: close_poll in the same cycle as cand_sel=4'b1000 -> tally[3] unchanged, SCAN entered.
  V6: rst_n low during SCAN -> IDLE, tallies 0, result_valid 0; result_ack in DONE -> IDLE, rd_count still returns tallies.
